// File: rtl/bus_map_pkg.sv
// Shared address map, FSM encoding and slave indices for the CPU bus interconnect.
// Region matching is a pure mask compare; masks derive from constant sizes only.
package bus_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int NUM_SLV    = 3;
  localparam int SLV_ROM    = 0;
  localparam int SLV_SRAM   = 1;
  localparam int SLV_PERIPH = 2;

  localparam logic [31:0] ROM_BASE_DEF    = 32'h0000_0000;
  localparam logic [31:0] SRAM_BASE_DEF   = 32'h0002_0000;
  localparam logic [31:0] SRAM_BYTES_DEF  = 32'h0001_0000;
  localparam logic [31:0] PERIPH_BASE_DEF = 32'h0100_0000;

  localparam logic [31:0] ROM_MASK    = 32'hFFFF_FFF0;
  localparam logic [31:0] PERIPH_MASK = 32'hFFFF_F000;

  function automatic logic [31:0] size_mask(input logic [31:0] bytes);
    return ~(bytes - 32'd1);
  endfunction

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// ACCESS-phase watchdog: cleared when a transfer starts, counts while the
// access is outstanding, and flags expiry in the last allowed cycle.
module bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic active,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Holds at LAST so the counter can never wrap back into a live range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (active && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = active && (count == LAST);

endmodule

// File: rtl/bus_interconnect.sv
// Single-master interconnect: decodes a CPU request onto ROM, SRAM or a
// peripheral slave, with a forced error completion for unmapped or stuck accesses.
module bus_interconnect
  import bus_map_pkg::*;
#(
  parameter logic [31:0] ROM_BASE       = ROM_BASE_DEF,
  parameter logic [31:0] SRAM_BASE      = SRAM_BASE_DEF,
  parameter logic [31:0] SRAM_BYTES     = SRAM_BYTES_DEF,
  parameter logic [31:0] PERIPH_BASE    = PERIPH_BASE_DEF,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [29:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic [3:0]  slv_wstrb,
  output logic        rom_select,
  output logic        sram_select,
  output logic        periph_select,
  input  logic        rom_ready,
  input  logic        sram_ready,
  input  logic        periph_ready,
  input  logic [31:0] rom_rdata,
  input  logic [31:0] sram_rdata,
  input  logic [31:0] periph_rdata,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam logic [31:0] SRAM_MASK = size_mask(SRAM_BYTES);

  state_t               state, state_next;
  logic [NUM_SLV-1:0]   sel, dec;
  logic [31:0]          req_addr;
  logic [31:0]          sel_rdata;
  logic                 mapped, accept, in_access, sel_ready, expire;
  logic                 unused;

  assign unused = mem_instr;

  always_comb begin
    dec = '0;
    if (region_hit(mem_addr, ROM_BASE, ROM_MASK)) begin
      dec[SLV_ROM] = 1'b1;
    end else if (region_hit(mem_addr, SRAM_BASE, SRAM_MASK)) begin
      dec[SLV_SRAM] = 1'b1;
    end else if (region_hit(mem_addr, PERIPH_BASE, PERIPH_MASK)) begin
      dec[SLV_PERIPH] = 1'b1;
    end
  end

  assign mapped    = |dec;
  assign in_access = (state == ST_ACCESS);
  assign accept    = (state == ST_IDLE) && mem_valid && mapped;

  // Only the selected slave's ready counts, and sel is zero outside ACCESS.
  assign sel_ready = (sel[SLV_ROM]    & rom_ready)  |
                     (sel[SLV_SRAM]   & sram_ready) |
                     (sel[SLV_PERIPH] & periph_ready);

  always_comb begin
    sel_rdata = '0;
    if (sel[SLV_ROM])         sel_rdata = rom_rdata;
    else if (sel[SLV_SRAM])   sel_rdata = sram_rdata;
    else if (sel[SLV_PERIPH]) sel_rdata = periph_rdata;
  end

  bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (accept),
    .active (in_access),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (mem_valid) state_next = mapped ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (sel_ready || expire) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel       <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_wstrb <= '0;
      req_addr  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_valid && mapped) begin
            sel       <= dec;
            slv_addr  <= mem_addr[31:2];
            slv_wdata <= mem_wdata;
            slv_wstrb <= mem_wstrb;
            req_addr  <= mem_addr;
          end else if (mem_valid) begin
            mem_ready <= 1'b1;
            mem_rdata <= '0;
            bus_err   <= 1'b1;
            err_addr  <= mem_addr;
          end
        end
        ST_ACCESS: begin
          // A ready in the expiry cycle still wins: the data is real.
          if (sel_ready) begin
            sel       <= '0;
            mem_ready <= 1'b1;
            mem_rdata <= sel_rdata;
          end else if (expire) begin
            sel       <= '0;
            mem_ready <= 1'b1;
            mem_rdata <= '0;
            bus_err   <= 1'b1;
            err_addr  <= req_addr;
          end
        end
        ST_RESP: begin
          mem_ready <= 1'b0;
          bus_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rom_select    = sel[SLV_ROM];
  assign sram_select   = sel[SLV_SRAM];
  assign periph_select = sel[SLV_PERIPH];

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect with behavioural ROM/SRAM/peripheral
// slaves and a queue of expected completions.
module tb_bus_interconnect;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [29:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_wstrb;
  logic        rom_select, sram_select, periph_select;
  logic        rom_ready = 1'b0, sram_ready = 1'b0, periph_ready = 1'b0;
  logic [31:0] rom_rdata = '0, sram_rdata = '0, periph_rdata;
  logic        bus_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;
  int psel_cnt = 0;
  logic periph_en = 1'b1;
  logic [31:0] last_err = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] rom_words [4];
  logic [31:0] sram_mem [16];

  always #5 clk = ~clk;

  bus_interconnect #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .rom_select(rom_select), .sram_select(sram_select), .periph_select(periph_select),
    .rom_ready(rom_ready), .sram_ready(sram_ready), .periph_ready(periph_ready),
    .rom_rdata(rom_rdata), .sram_rdata(sram_rdata), .periph_rdata(periph_rdata),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  // Slave models: registered ready one cycle after select.
  always @(posedge clk) begin
    rom_ready <= rom_select;
    rom_rdata <= rom_words[slv_addr[1:0]];
    sram_ready <= sram_select;
    sram_rdata <= (|slv_wstrb) ? 32'h0 : sram_mem[slv_addr[3:0]];
    if (sram_select) begin
      for (int b = 0; b < 4; b++)
        if (slv_wstrb[b]) sram_mem[slv_addr[3:0]][8*b +: 8] <= slv_wdata[8*b +: 8];
    end
    periph_ready <= periph_select & periph_en;
  end
  assign periph_rdata = 32'hCAFE_0042;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1)
      check("onehot", 32'($countones({periph_select, sram_select, rom_select}) > 1), 32'd0);
    if (periph_select === 1'b1) psel_cnt++;
  end

  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] sel,
                         input logic [31:0] rdata, input logic err, input int lat,
                         input bit drop, input string tag);
    exp_t e;
    int n;
    e.rdata = rdata; e.err = err; e.lat = lat;
    sb.push_back(e);
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_valid = 1'b1;
    @(posedge clk); #1;
    n = 1;
    check({tag, " sel"}, 32'({periph_select, sram_select, rom_select}), 32'(sel));
    if (sel != 3'b000) begin
      check({tag, " slv_addr"}, 32'(slv_addr), 32'(addr[31:2]));
      check({tag, " slv_wdata"}, slv_wdata, wdata);
      check({tag, " slv_wstrb"}, 32'(slv_wstrb), 32'(wstrb));
    end
    if (drop) begin
      mem_valid = 1'b0;
      mem_addr  = 32'hFFFF_FFFC;
    end
    while (mem_ready !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    mem_valid = 1'b0;
    e = sb.pop_front();
    check({tag, " ready"}, 32'(mem_ready), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(e.lat));
    check({tag, " rdata"}, mem_rdata, e.rdata);
    check({tag, " bus_err"}, 32'(bus_err), 32'(e.err));
    if (e.err) last_err = addr;
    check({tag, " err_addr"}, err_addr, last_err);
    @(posedge clk); #1;
    check({tag, " pulse_end"}, 32'({mem_ready, bus_err}), 32'd0);
  endtask

  initial begin
    rom_words[0] = 32'h0002_02b7;
    rom_words[1] = 32'h0002_8067;
    rom_words[2] = 32'h0000_0013;
    rom_words[3] = 32'h1234_5678;
    for (int i = 0; i < 16; i++) sram_mem[i] = '0;
    reset_n = 1'b0;
    mem_valid = 1'b0; mem_instr = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ctl", 32'({mem_ready, bus_err, rom_select, sram_select, periph_select}), 32'd0);
    check("reset rdata", mem_rdata, 32'd0);
    check("reset err_addr", err_addr, 32'd0);
    check("reset slv_addr", 32'(slv_addr), 32'd0);
    reset_n = 1'b1;

    do_xfer(32'h0000_0000, 32'h0, 4'h0, 3'b001, 32'h0002_02b7, 1'b0, 3, 1'b0, "rom0");
    do_xfer(32'h0000_0004, 32'h0, 4'h0, 3'b001, 32'h0002_8067, 1'b0, 3, 1'b0, "rom4");
    do_xfer(32'h0002_0010, 32'hA5A5_5A5A, 4'hF, 3'b010, 32'h0, 1'b0, 3, 1'b0, "sram_wr");
    do_xfer(32'h0002_0010, 32'h0, 4'h0, 3'b010, 32'hA5A5_5A5A, 1'b0, 3, 1'b1, "sram_rd_drop");
    do_xfer(32'h0800_0000, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1, 1'b0, "unmapped");
    do_xfer(32'h0100_0020, 32'h0, 4'h0, 3'b100, 32'hCAFE_0042, 1'b0, 3, 1'b0, "periph");
    do_xfer(32'h0000_0008, 32'h1111_2222, 4'hF, 3'b001, 32'h0000_0013, 1'b0, 3, 1'b0, "rom_wr");

    periph_en = 1'b0;
    psel_cnt = 0;
    do_xfer(32'h0100_0004, 32'h0, 4'h0, 3'b100, 32'h0, 1'b1, 9, 1'b1, "timeout");
    check("timeout sel_cycles", 32'(psel_cnt), 32'd8);
    periph_en = 1'b1;

    do_xfer(32'h0000_000C, 32'h0, 4'h0, 3'b001, 32'h1234_5678, 1'b0, 3, 1'b0, "rom_c");

    // Reset asserted mid-ACCESS must clear outputs without waiting for a clock.
    mem_addr = 32'h0000_0004; mem_wdata = 32'h5555_AAAA; mem_wstrb = 4'h3; mem_valid = 1'b1;
    @(posedge clk); #1;
    check("midreset pre sel", 32'(rom_select), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset ctl", 32'({mem_ready, bus_err, rom_select, sram_select, periph_select}), 32'd0);
    check("midreset rdata", mem_rdata, 32'd0);
    check("midreset err_addr", err_addr, 32'd0);
    check("midreset slv_addr", 32'(slv_addr), 32'd0);
    check("midreset slv_w", slv_wdata | 32'(slv_wstrb), 32'd0);
    mem_valid = 1'b0;
    last_err = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_xfer(32'h0000_0000, 32'h0, 4'h0, 3'b001, 32'h0002_02b7, 1'b0, 3, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 SHALL have parameter ROM_BASE, default 32'h0000_0000, byte base of the 16-byte boot ROM region.
REQ-002 SHALL have parameter SRAM_BASE, default 32'h0002_0000, byte base of the SRAM region.
REQ-003 SHALL have parameter SRAM_BYTES, default 32'h0001_0000, SRAM region size, power of two.
REQ-004 SHALL have parameter PERIPH_BASE, default 32'h0100_0000, byte base of a 4 KiB peripheral region.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before a forced error completion.
REQ-006 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports mem_valid, input, 1, and mem_instr, input, 1: CPU request valid and fetch flag (flag ignored).
REQ-009 SHALL have ports mem_addr, input, 32, mem_wdata, input, 32, and mem_wstrb, input, 4: CPU request fields; wstrb 0 means read.
REQ-010 SHALL have ports mem_ready, output, 1, and mem_rdata, output, 32: completion strobe and read data.
REQ-011 SHALL have ports slv_addr, output, 30, slv_wdata, output, 32, and slv_wstrb, output, 4: word address and write fields broadcast to all slaves.
REQ-012 SHALL have ports rom_select, sram_select and periph_select, each output, 1: per-slave selects.
REQ-013 SHALL have ports rom_ready, sram_ready and periph_ready, each input, 1, and rom_rdata, sram_rdata and periph_rdata, each input, 32: per-slave responses.
REQ-014 SHALL have port bus_err, output, 1: one-cycle pulse coincident with an error completion.
REQ-015 SHALL have port err_addr, output, 32: mem_addr of the most recent error completion.

Function
REQ-016 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-017 In IDLE with mem_valid=1, SHALL decode mem_addr; mapped goes to ACCESS, unmapped goes to RESP with error.
REQ-018 SHALL register the selected slave's select to 1 on the IDLE->ACCESS edge and hold it through ACCESS.
REQ-019 SHALL latch slv_addr = mem_addr[31:2], slv_wdata and slv_wstrb on the IDLE->ACCESS edge, stable until IDLE.
REQ-020 SHALL sample only the selected slave's ready, and only in ACCESS; stale ready in RESP/IDLE SHALL be ignored.
REQ-021 In ACCESS, on selected ready=1, SHALL latch that slave's rdata into mem_rdata, clear select, and go to RESP.
REQ-022 In ACCESS, on TIMEOUT_CYCLES elapsed without ready, SHALL clear select, set mem_rdata=0, flag error, and go to RESP.
REQ-023 In RESP, SHALL drive mem_ready=1 for exactly one cycle, then go to IDLE.
REQ-024 For error completions, mem_rdata SHALL be 0, bus_err SHALL pulse with mem_ready, and err_addr SHALL be updated.
REQ-025 Latency for a slave with 1-cycle registered ready SHALL be: mem_valid sampled at edge 0, select high after edge 0, ready seen after edge 1, mem_ready high after edge 2 for one cycle.
REQ-026 At most one select SHALL be high in any cycle.
REQ-027 Writes to ROM SHALL complete normally with no error.
REQ-028 mem_valid falling during ACCESS SHALL be ignored; the transfer SHALL complete.
REQ-029 Region matching SHALL use an address-mask compare with no arithmetic; ROM matches mem_addr[31:4]==ROM_BASE[31:4].

Reset
REQ-030 Asserting reset_n=0 SHALL immediately force IDLE, all selects=0, mem_ready=0, mem_rdata=0, bus_err=0, err_addr=0, timeout counter=0, slv_*=0, including mid-ACCESS.
REQ-031 The first transfer SHALL be accepted on the first edge after reset_n deasserts with mem_valid=1.

Structure
REQ-032 Shared package bus_map_pkg SHALL hold region bases and masks, state encoding, and slave index constants.
REQ-033 Timeout counting SHALL be one sub-module, bus_timeout: clear on ACCESS entry, count in ACCESS, expire pulse at TIMEOUT_CYCLES.

Verification
REQ-034 ROM read at 0x0 with ROM model (ready<=select) -> mem_rdata=0x000202b7, mem_ready one cycle, latency per REQ-025.
REQ-035 SRAM write 0x0002_0010, wdata 0xA5A5_5A5A, wstrb 4'hF -> sram_select only, slv_addr=0x8004, no bus_err.
REQ-036 Read 0x0800_0000 (unmapped) -> no select, mem_ready after 1 cycle, mem_rdata=0, bus_err pulse, err_addr=0x0800_0000.
REQ-037 Periph read, periph_ready tied 0, TIMEOUT_CYCLES=8 -> periph_select high 8 cycles, then mem_ready with rdata=0 and bus_err.
REQ-038 reset_n low mid-ACCESS -> all outputs 0 asynchronously; next ROM read after release completes correctly.
REQ-039 Back-to-back ROM reads at 0x0 then 0x4 -> second returns 0x00028067; stale ROM ready is not taken as second completion.
